// File: rtl/bypass_ctrl_pipeline_pkg.sv
// ---------------------------------------------------------------------------
// BypassTypes
//   Shared types for the bypass control pipeline.
//   - laneWidth() : lane index width derivation ($clog2, minimum 1)
//   - LANE_W      : lane field width for the default lane count
//   - BypassStage : which pipeline level supplies the operand (EX / WB)
//   - BypassCtrl  : {valid, stage, lane} select for the bypass data muxes
//   Optional feature macro used by the design: BYPASS_WB_STAGE_EN.
// ---------------------------------------------------------------------------
package BypassTypes;

  localparam int DEFAULT_LANES  = 2;
  localparam int DEFAULT_PREG_W = 7;

  function automatic int laneWidth(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

  // The lane field of BypassCtrl is sized for DEFAULT_LANES. Builds with a
  // larger lane count must raise DEFAULT_LANES so the field stays wide enough.
  localparam int LANE_W = laneWidth(DEFAULT_LANES);

  typedef enum logic {
    STAGE_EX = 1'b0,
    STAGE_WB = 1'b1
  } BypassStage;

  typedef struct packed {
    logic              valid;
    BypassStage        stage;
    logic [LANE_W-1:0] lane;
  } BypassCtrl;

endpackage

// File: rtl/bypass_ctrl_pipeline_if.sv
// ---------------------------------------------------------------------------
// bypass_ctrl_pipeline_if
//   Bundles the register-read stage inputs and the registered bypass selects.
//   There is no valid/ready handshake on this bus: every cycle carries one
//   issue group; stall holds all state and outputs, flush empties them.
//   Signals:
//     stall, flush        pipeline control
//     srcA/srcB[LANES]    consumer source register numbers (RR stage)
//     readA/readB[LANES]  operand is actually read
//     dst[LANES]          producer destination register number (RR stage)
//     writeReg[LANES]     lane writes dst
//     ctrlA/ctrlB[LANES]  registered BypassCtrl per operand (EX stage)
//   Modports: master = register-read stage side, slave = bypass controller.
// ---------------------------------------------------------------------------
interface bypass_ctrl_pipeline_if
  import BypassTypes::*;
#(
  parameter int LANES  = DEFAULT_LANES,
  parameter int PREG_W = DEFAULT_PREG_W
);

  logic                          stall;
  logic                          flush;
  logic [LANES-1:0][PREG_W-1:0]  srcA;
  logic [LANES-1:0][PREG_W-1:0]  srcB;
  logic [LANES-1:0]              readA;
  logic [LANES-1:0]              readB;
  logic [LANES-1:0][PREG_W-1:0]  dst;
  logic [LANES-1:0]              writeReg;
  BypassCtrl [LANES-1:0]         ctrlA;
  BypassCtrl [LANES-1:0]         ctrlB;

  modport master (
    output stall, flush, srcA, srcB, readA, readB, dst, writeReg,
    input  ctrlA, ctrlB
  );

  modport slave (
    input  stall, flush, srcA, srcB, readA, readB, dst, writeReg,
    output ctrlA, ctrlB
  );

endinterface

// File: rtl/bypass_ctrl_pipeline_match_unit.sv
// ---------------------------------------------------------------------------
// bypass_match_unit
//   Combinational comparison of one consumer source register against both
//   producer levels. Any P1 (EX) hit beats any P2 (WB) hit; within a level
//   the lowest lane index wins. No hit (or operand not read) gives all zero.
//   Ports:
//     srcReg, readEn     consumer operand number and its read flag
//     p1Valid, p1Dst     distance-1 producers, one per lane
//     p2Valid, p2Dst     distance-2 producers, one per lane
//     ctrl               resulting BypassCtrl
// ---------------------------------------------------------------------------
module bypass_match_unit
  import BypassTypes::*;
#(
  parameter int LANES  = DEFAULT_LANES,
  parameter int PREG_W = DEFAULT_PREG_W
) (
  input  logic [PREG_W-1:0]             srcReg,
  input  logic                          readEn,
  input  logic [LANES-1:0]              p1Valid,
  input  logic [LANES-1:0][PREG_W-1:0]  p1Dst,
  input  logic [LANES-1:0]              p2Valid,
  input  logic [LANES-1:0][PREG_W-1:0]  p2Dst,
  output BypassCtrl                     ctrl
);

  always_comb begin
    ctrl = '0;
    if (readEn) begin
      // Scan the older level first and the younger level last, each from the
      // highest lane down, so the final assignment is the winning hit.
      for (int l = LANES - 1; l >= 0; l--) begin
        if (p2Valid[l] && (p2Dst[l] == srcReg)) begin
          ctrl.valid = 1'b1;
          ctrl.stage = STAGE_WB;
          ctrl.lane  = LANE_W'(l);
        end
      end
      for (int l = LANES - 1; l >= 0; l--) begin
        if (p1Valid[l] && (p1Dst[l] == srcReg)) begin
          ctrl.valid = 1'b1;
          ctrl.stage = STAGE_EX;
          ctrl.lane  = LANE_W'(l);
        end
      end
    end
  end

endmodule

// File: rtl/bypass_ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// bypass_ctrl_pipeline
//   Tracks destination registers of in-flight producers (P1 = EX distance,
//   P2 = WB distance), compares RR-stage consumer sources against them and
//   registers a per-operand bypass select for the EX stage one cycle later.
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset, clears all state immediately
//     bus   bypass_ctrl_pipeline_if.slave (stall, flush, RR inputs, ctrl out)
//   Optional feature: BYPASS_WB_STAGE_EN builds the P2 level and reports WB
//   hits; without it only P1 hits are reported and stage is always EX, so
//   distance-2 dependences rely on a write-before-read register file.
// ---------------------------------------------------------------------------
module bypass_ctrl_pipeline
  import BypassTypes::*;
#(
  parameter int LANES  = DEFAULT_LANES,
  parameter int PREG_W = DEFAULT_PREG_W
) (
  input  logic                   clk,
  input  logic                   rst,
  bypass_ctrl_pipeline_if.slave  bus
);

  logic [LANES-1:0]              p1Valid;
  logic [LANES-1:0][PREG_W-1:0]  p1Dst;
  logic [LANES-1:0]              p2Valid;
  logic [LANES-1:0][PREG_W-1:0]  p2Dst;

  BypassCtrl [LANES-1:0]         nextA;
  BypassCtrl [LANES-1:0]         nextB;
  BypassCtrl [LANES-1:0]         ctrlAQ;
  BypassCtrl [LANES-1:0]         ctrlBQ;

  // Distance-1 producer level. Same-cycle RR producers never feed the match
  // units; the scheduler keeps dependent instructions out of one group.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p1Valid <= '0;
      p1Dst   <= '0;
    end else if (bus.flush) begin
      p1Valid <= '0;
    end else if (!bus.stall) begin
      p1Valid <= bus.writeReg;
      p1Dst   <= bus.dst;
    end
  end

`ifdef BYPASS_WB_STAGE_EN
  // Distance-2 producer level: P1 ages into P2 on every non-stalled edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p2Valid <= '0;
      p2Dst   <= '0;
    end else if (bus.flush) begin
      p2Valid <= '0;
    end else if (!bus.stall) begin
      p2Valid <= p1Valid;
      p2Dst   <= p1Dst;
    end
  end
`else
  // No WB level: the match units see an empty P2 and never report WB.
  assign p2Valid = '0;
  assign p2Dst   = '0;
`endif

  for (genvar g = 0; g < LANES; g++) begin : gen_match
    bypass_match_unit #(
      .LANES  (LANES),
      .PREG_W (PREG_W)
    ) u_match_a (
      .srcReg  (bus.srcA[g]),
      .readEn  (bus.readA[g]),
      .p1Valid (p1Valid),
      .p1Dst   (p1Dst),
      .p2Valid (p2Valid),
      .p2Dst   (p2Dst),
      .ctrl    (nextA[g])
    );

    bypass_match_unit #(
      .LANES  (LANES),
      .PREG_W (PREG_W)
    ) u_match_b (
      .srcReg  (bus.srcB[g]),
      .readEn  (bus.readB[g]),
      .p1Valid (p1Valid),
      .p1Dst   (p1Dst),
      .p2Valid (p2Valid),
      .p2Dst   (p2Dst),
      .ctrl    (nextB[g])
    );
  end

  // Output registers: the only path from the RR inputs to the EX-stage
  // selects, so there is no combinational input-to-output path.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrlAQ <= '0;
      ctrlBQ <= '0;
    end else if (bus.flush) begin
      ctrlAQ <= '0;
      ctrlBQ <= '0;
    end else if (!bus.stall) begin
      ctrlAQ <= nextA;
      ctrlBQ <= nextB;
    end
  end

  assign bus.ctrlA = ctrlAQ;
  assign bus.ctrlB = ctrlBQ;

endmodule

// File: tb/tb_bypass_ctrl_pipeline.sv
// ---------------------------------------------------------------------------
// tb_bypass_ctrl_pipeline
//   Directed bench for bypass_ctrl_pipeline with two lanes. Each case drives
//   one RR issue group per clock and compares the 3-bit {valid,stage,lane}
//   selects against hand-computed values.
// ---------------------------------------------------------------------------
module tb_bypass_ctrl_pipeline;
  import BypassTypes::*;

  localparam int LANES  = 2;
  localparam int PREG_W = 7;

  localparam logic [2:0] NONE  = 3'b000;
  localparam logic [2:0] EX_L0 = 3'b100;
  localparam logic [2:0] EX_L1 = 3'b101;
  localparam logic [2:0] WB_L1 = 3'b111;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bypass_ctrl_pipeline_if #(.LANES(LANES), .PREG_W(PREG_W)) bus ();

  bypass_ctrl_pipeline #(
    .LANES  (LANES),
    .PREG_W (PREG_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking
  task automatic check_eq(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  // Drivers
  task automatic clear_inputs();
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.srcA     = '0;
    bus.srcB     = '0;
    bus.readA    = '0;
    bus.readB    = '0;
    bus.dst      = '0;
    bus.writeReg = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    repeat (n) tick();
  endtask

  task automatic produce(input int lane, input logic [PREG_W-1:0] d);
    bus.writeReg[lane] = 1'b1;
    bus.dst[lane]      = d;
  endtask

  task automatic consume_a(input int lane, input logic [PREG_W-1:0] s);
    bus.readA[lane] = 1'b1;
    bus.srcA[lane]  = s;
  endtask

  task automatic consume_b(input int lane, input logic [PREG_W-1:0] s);
    bus.readB[lane] = 1'b1;
    bus.srcB[lane]  = s;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    clear_inputs();

    // Reset state
    #3;
    check_eq("reset_a0", bus.ctrlA[0], NONE);
    check_eq("reset_a1", bus.ctrlA[1], NONE);
    check_eq("reset_b0", bus.ctrlB[0], NONE);
    check_eq("reset_b1", bus.ctrlB[1], NONE);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    idle(1);

    // Distance 1: lane0 writes 5, lane1 reads it next cycle
    produce(0, 7'd5);
    tick();
    clear_inputs();
    consume_a(1, 7'd5);
    tick();
    check_eq("dist1_a1", bus.ctrlA[1], EX_L0);
    check_eq("dist1_a0", bus.ctrlA[0], NONE);
    idle(2);

    // P1 beats P2: lane1 writes 9, then lane0 writes 9, then consumer
    produce(1, 7'd9);
    tick();
    clear_inputs();
    produce(0, 7'd9);
    tick();
    clear_inputs();
    consume_b(0, 7'd9);
    tick();
    check_eq("p1_beats_p2", bus.ctrlB[0], EX_L0);
    idle(2);

    // Distance 2 only, then distance 3
    produce(1, 7'd9);
    tick();
    idle(1);
    consume_b(0, 7'd9);
    tick();
`ifdef BYPASS_WB_STAGE_EN
    check_eq("dist2_wb", bus.ctrlB[0], WB_L1);
`else
    check_eq("dist2_wb", bus.ctrlB[0], NONE);
`endif
    clear_inputs();
    consume_b(0, 7'd9);
    tick();
    check_eq("dist3_none", bus.ctrlB[0], NONE);
    idle(2);

    // Same level, two hits: lowest lane wins
    produce(0, 7'd12);
    produce(1, 7'd12);
    tick();
    clear_inputs();
    consume_a(0, 7'd12);
    consume_a(1, 7'd12);
    tick();
    check_eq("same_lvl_a0", bus.ctrlA[0], EX_L0);
    check_eq("same_lvl_a1", bus.ctrlA[1], EX_L0);
    idle(2);

    // readA=0 masks a match; readB=1 on the same number still hits
    produce(0, 7'd20);
    tick();
    clear_inputs();
    bus.srcA[1] = 7'd20;
    consume_b(1, 7'd20);
    tick();
    check_eq("read_off_a1", bus.ctrlA[1], NONE);
    check_eq("read_on_b1", bus.ctrlB[1], EX_L0);
    idle(2);

    // writeReg=0 on the producer
    bus.dst[0] = 7'd21;
    tick();
    clear_inputs();
    consume_a(1, 7'd21);
    tick();
    check_eq("write_off", bus.ctrlA[1], NONE);
    idle(2);

    // Register 0 is an ordinary register
    produce(1, 7'd0);
    tick();
    clear_inputs();
    consume_a(0, 7'd0);
    tick();
    check_eq("reg0_hit", bus.ctrlA[0], EX_L1);

    // Stall holds the output registers
    clear_inputs();
    bus.stall = 1'b1;
    consume_a(0, 7'd50);
    tick();
    check_eq("stall_hold", bus.ctrlA[0], EX_L1);
    idle(2);

    // Stall does not age a producer
    produce(0, 7'd3);
    tick();
    clear_inputs();
    bus.stall = 1'b1;
    tick();
    clear_inputs();
    consume_a(1, 7'd3);
    tick();
    check_eq("stall_keep_ex", bus.ctrlA[1], EX_L0);
    idle(2);

    // Flush with simultaneous new producer: pipeline empty afterwards
    produce(0, 7'd3);
    tick();
    clear_inputs();
    bus.flush = 1'b1;
    produce(1, 7'd3);
    tick();
    check_eq("flush_out_a1", bus.ctrlA[1], NONE);
    clear_inputs();
    consume_a(1, 7'd3);
    consume_b(0, 7'd3);
    tick();
    check_eq("flush_a1", bus.ctrlA[1], NONE);
    check_eq("flush_b0", bus.ctrlB[0], NONE);
    idle(2);

    // Flush beats stall
    produce(0, 7'd3);
    tick();
    clear_inputs();
    produce(0, 7'd3);
    consume_a(1, 7'd3);
    tick();
    check_eq("pre_fs_a1", bus.ctrlA[1], EX_L0);
    clear_inputs();
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    consume_a(0, 7'd3);
    tick();
    check_eq("fs_out_a1", bus.ctrlA[1], NONE);
    clear_inputs();
    consume_a(1, 7'd3);
    tick();
    check_eq("fs_p1_clear", bus.ctrlA[1], NONE);
    idle(2);

    // Asynchronous reset mid-run clears outputs before any edge
    produce(0, 7'd7);
    tick();
    clear_inputs();
    produce(0, 7'd8);
    consume_a(1, 7'd7);
    tick();
    check_eq("pre_rst_a1", bus.ctrlA[1], EX_L0);
    #1 rst = 1'b0;
    #1;
    check_eq("async_rst_a1", bus.ctrlA[1], NONE);
    #1 rst = 1'b1;
    clear_inputs();
    consume_a(1, 7'd8);
    tick();
    check_eq("rst_p1_clear", bus.ctrlA[1], NONE);

    // First valid output one edge after first input following reset
    clear_inputs();
    produce(1, 7'd44);
    tick();
    clear_inputs();
    consume_b(1, 7'd44);
    tick();
    check_eq("post_rst_hit", bus.ctrlB[1], EX_L1);
    idle(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bypass_ctrl_pipeline.md
# bypass_ctrl_pipeline

- Tracks destination physical-register numbers of in-flight producers.
- Compares each consumer source register number against them in the register-read stage.
- Delivers a registered per-operand bypass select to the execution stage one cycle later.
- Sits between the register-read stages (upstream) and the bypass network data muxes (downstream); drives the network's control inputs.

## Interface
Parameters:
- LANES, 2, number of issue lanes; each lane is both a producer and a consumer.
- PREG_W, 7, physical register number width.
- LANE_W, $clog2(LANES) (min 1), lane index width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset; asserting clears all state immediately.
- stall  in  1  hold all pipeline and output registers.
- flush  in  1  invalidate all in-flight producers and outputs.
- srcA[LANES]  in  PREG_W  operand A physical register number (RR stage).
- srcB[LANES]  in  PREG_W  operand B physical register number (RR stage).
- readA[LANES], readB[LANES]  in  1  operand is actually read.
- dst[LANES]  in  PREG_W  destination physical register number (RR stage).
- writeReg[LANES]  in  1  lane writes dst.
- ctrlA[LANES], ctrlB[LANES]  out  {valid,stage,lane} = 1+1+LANE_W  registered bypass select for the EX stage.
  - stage: 0 = EX result, 1 = WB result.

## Operation
- Producer pipeline, two levels per lane:
  - P1 holds {valid, dst} of the lane's RR instruction from the previous cycle, i.e. distance 1 (EX).
  - P2 holds P1's previous contents, i.e. distance 2 (WB).
- Each edge, when not stalled: P1 <= {writeReg, dst}; P2 <= P1.
- Match rule for operand X of lane i: hit on entry e when read X=1, e.valid=1, and e.dst == srcX.
- Priority among hits:
  - Any P1 hit beats any P2 hit (younger producer wins).
  - Within a level, the lowest lane index wins.
- Result is {valid=1, stage, lane}; with no hit, {0,0,0} (read from register file).
- Same-cycle RR producers are never matched (no intra-group bypass; the scheduler guarantees this).
- Register number 0 is treated like any other register; no special case.
- flush: next edge clears P1.valid, P2.valid and all ctrl outputs to zero; flush has priority over stall.
- stall without flush: P1, P2 and ctrl outputs hold their values.
- Reset values: every ctrlA/ctrlB = {0,0,0}; all P1/P2 valid = 0.

## Timing
- Latency: operands presented in cycle t produce ctrl outputs valid from the edge ending cycle t through cycle t+1 (EX).
- No combinational path from inputs to outputs.
- A producer in RR at cycle t is matched as stage=EX by consumers in RR at t+1, and as stage=WB at t+2.
- After t+2 it is no longer bypassed; the register file holds the value.
- Stall cycles do not advance distance; a held producer keeps its level.
- Simultaneous flush and new RR inputs: inputs are discarded, pipeline empty after the edge.
- Reset released mid-stream: first valid output appears one edge after the first non-stalled, non-flushed input.

## Configuration
- BYPASS_WB_STAGE_EN defined: two-level tracking (P1, P2) as above; stage field is 1 bit.
- Undefined:
  - P2 is not built; only P1 hits are reported.
  - stage output is tied to 0.
  - Distance-2 dependences read the register file; the register file must have write-before-read semantics for them.

## Structure
- Shared package BypassTypes holds:
  - The BypassCtrl struct {valid, stage, lane}.
  - The BypassStage enum (EX=0, WB=1).
  - The LANE_W derivation.
- Sub-module bypass_match_unit, instantiated 2×LANES times:
  - Purely combinational.
  - Takes one source number, its read flag and both producer levels.
  - Returns a BypassCtrl using the priority rule above.

## Test plan
- Reset: assert rst low mid-run with outputs nonzero → all ctrl outputs {0,0,0} immediately, before any clock edge.
- Distance 1: lane0 writes dst=5 at t; lane1 srcA=5 at t+1 → ctrlA[1]={1,EX,0} at t+2.
- Distance 2 and priority:
  - Lane1 writes 9 at t and lane0 writes 9 at t+1; lane0 srcB=9 at t+2 → ctrlB[0]={1,EX,0} (P1 beats P2).
  - With macro on: only the t write, consumer at t+2 → {1,WB,1}.
- Same level, two hits: both lanes write 12 at t; consumer srcA=12 at t+1 → lane=0.
- readA=0 with a matching src, or writeReg=0 on the producer → valid=0.
- Stall/flush:
  - Producer dst=3 at t, stall at t+1, consumer srcA=3 at t+2 → still stage EX.
  - Flush at t+1 instead → valid=0.
  - flush and stall both high → flush wins.
